// File: rtl/alu_sequencer_if.sv
// Bus bundle between alu_sequencer and its instruction memory, data memory,
// register bank and alu_control datapath.
interface alu_sequencer_if;
  // Handshake: a request stays high while its wait state lasts. The ack that
  // ends that state is accepted on the same edge. Any ack seen outside the
  // matching wait state is ignored.
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [3:0]  alu_cond;
  logic [3:0]  alu_opcode;
  logic        alu_s;
  logic [2:0]  alu_shift;
  logic [15:0] alu_imm;
  logic [3:0]  rf_addr1;
  logic [3:0]  rf_addr2;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic        wb_sel;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic        dmem_req;
  logic [7:0]  dmem_addr;
  logic        dmem_ack;

  modport master (
    output imem_req, imem_addr, alu_cond, alu_opcode, alu_s, alu_shift, alu_imm,
           rf_addr1, rf_addr2, rf_we, rf_waddr, wb_sel, dmem_req, dmem_addr,
    input  imem_ack, imem_data, alu_result, alu_flags, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, alu_cond, alu_opcode, alu_s, alu_shift, alu_imm,
           rf_addr1, rf_addr2, rf_we, rf_waddr, wb_sel, dmem_req, dmem_addr,
    output imem_ack, imem_data, alu_result, alu_flags, dmem_ack
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback controller for alu_control.
// Optional STALL_TIMEOUT_EN: 16-cycle ack timeout in FETCH/MEMORY forcing HALT.
module alu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] PC_STEP  = 8'd1
) (
  input  logic                   trigger,
  input  logic                   reset,
  input  logic                   run,
  alu_sequencer_if.master        bus,
  output logic [3:0]             flags,
  output logic [7:0]             pc,
  output logic                   halted,
  output logic [2:0]             state
`ifdef STALL_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [3:0] OP_CMP  = 4'b1000;
  localparam logic [3:0] OP_LDR  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t      cur;
  logic [31:0] ir;
  logic        cond_pass;
  logic        unused_result_bits;

`ifdef STALL_TIMEOUT_EN
  logic [3:0]  wait_cnt;
`endif

  assign state         = cur;
  assign bus.imem_addr = pc;
  assign bus.alu_cond   = ir[31:28];
  assign bus.alu_opcode = ir[27:24];
  assign bus.alu_s      = ir[23];
  assign bus.alu_shift  = ir[22:20];
  assign bus.rf_waddr   = ir[19:16];
  assign bus.rf_addr1   = ir[15:12];
  assign bus.rf_addr2   = ir[11:8];
  assign bus.alu_imm    = ir[15:0];
  assign unused_result_bits = ^bus.alu_result[31:8];

  // Flags are NZCV; CMP uses the cond field as its comparison selector, so it always runs.
  always_comb begin
    cond_pass = 1'b0;
    case (ir[31:28])
      4'b0000: cond_pass = 1'b1;
      4'b0001: cond_pass = flags[2];
      4'b0010: cond_pass = !flags[2] && (flags[3] == flags[0]);
      4'b0011: cond_pass = (flags[3] != flags[0]);
      4'b0100: cond_pass = !flags[2];
      4'b0101: cond_pass = (flags[3] == flags[0]);
      4'b0110: cond_pass = flags[1] && !flags[2];
      4'b0111: cond_pass = !flags[1] || flags[2];
      default: cond_pass = 1'b0;
    endcase
    if (ir[27:24] == OP_CMP) cond_pass = 1'b1;
  end

  always_ff @(posedge trigger or posedge reset) begin
    if (reset) begin
      cur           <= S_IDLE;
      pc            <= RESET_PC;
      ir            <= '0;
      flags         <= '0;
      halted        <= 1'b0;
      bus.imem_req  <= 1'b0;
      bus.rf_we     <= 1'b0;
      bus.wb_sel    <= 1'b0;
      bus.dmem_req  <= 1'b0;
      bus.dmem_addr <= '0;
`ifdef STALL_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      case (cur)
        S_IDLE: begin
          if (run) begin
            cur          <= S_FETCH;
            bus.imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir           <= bus.imem_data;
            bus.imem_req <= 1'b0;
            cur          <= S_DECODE;
`ifdef STALL_TIMEOUT_EN
            wait_cnt     <= '0;
          end else if (wait_cnt == 4'd15) begin
            wait_cnt     <= '0;
            bus.imem_req <= 1'b0;
            halted       <= 1'b1;
            timeout_err  <= 1'b1;
            cur          <= S_HALT;
          end else begin
            wait_cnt     <= wait_cnt + 4'd1;
`endif
          end
        end
        S_DECODE: begin
          if (ir[27:24] == OP_HALT) begin
            halted <= 1'b1;
            cur    <= S_HALT;
          end else if (!cond_pass) begin
            pc <= pc + PC_STEP;
            if (run) begin
              cur          <= S_FETCH;
              bus.imem_req <= 1'b1;
            end else begin
              cur <= S_IDLE;
            end
          end else begin
            cur <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (ir[23]) flags <= bus.alu_flags;
          if (ir[27:24] == OP_LDR) begin
            bus.dmem_addr <= bus.alu_result[7:0];
            bus.dmem_req  <= 1'b1;
            cur           <= S_MEMORY;
          end else begin
            bus.rf_we <= (ir[27:24] <= OP_CMP);
            cur       <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            bus.wb_sel   <= 1'b1;
            bus.rf_we    <= 1'b1;
            cur          <= S_WRITEBACK;
`ifdef STALL_TIMEOUT_EN
            wait_cnt     <= '0;
          end else if (wait_cnt == 4'd15) begin
            wait_cnt     <= '0;
            bus.dmem_req <= 1'b0;
            halted       <= 1'b1;
            timeout_err  <= 1'b1;
            cur          <= S_HALT;
          end else begin
            wait_cnt     <= wait_cnt + 4'd1;
`endif
          end
        end
        S_WRITEBACK: begin
          bus.rf_we  <= 1'b0;
          bus.wb_sel <= 1'b0;
          pc         <= pc + PC_STEP;
          if (run) begin
            cur          <= S_FETCH;
            bus.imem_req <= 1'b1;
          end else begin
            cur <= S_IDLE;
          end
        end
        S_HALT: begin
          cur <= S_HALT;
        end
        default: begin
          cur <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one task per scenario, inline checks,
// pass/total summary at the end.
module tb_alu_sequencer;

  logic       trigger;
  logic       reset;
  logic       run;
  logic [3:0] flags;
  logic [7:0] pc;
  logic       halted;
  logic [2:0] state;
`ifdef STALL_TIMEOUT_EN
  logic       timeout_err;
`endif

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .trigger (trigger),
    .reset   (reset),
    .run     (run),
    .bus     (bus.master),
    .flags   (flags),
    .pc      (pc),
    .halted  (halted),
    .state   (state)
`ifdef STALL_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [3:0] exp_q[$];

  // clock / reset
  initial trigger = 1'b0;
  always #5 trigger = ~trigger;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge trigger);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [3:0] op,
                                     input logic s, input logic [3:0] rd);
    mk = {cond, op, s, 3'b000, rd, 16'hABCD};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Drives one instruction from FETCH until the FSM settles in IDLE/FETCH/HALT.
  task automatic exec_one(input logic [31:0] word, input logic [31:0] res,
                          input logic [3:0] fl, input int mem_wait,
                          output int we_cnt, output int we_at, output int dreq_cnt,
                          output logic wbsel_at_we, output logic [3:0] waddr_at_we,
                          output logic [7:0] daddr);
    int guard;
    int cyc;
    we_cnt = 0; we_at = 0; dreq_cnt = 0;
    wbsel_at_we = 1'b0; waddr_at_we = '0; daddr = '0;
    bus.alu_result = res;
    bus.alu_flags  = fl;
    run = 1'b1;
    guard = 0;
    while (state != 3'd1 && guard < 20) begin
      step();
      guard++;
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = word;
    run = 1'b0;
    step();
    bus.imem_ack = 1'b0;
    cyc = 2;
    guard = 0;
    while (!(state == 3'd0 || state == 3'd1 || state == 3'd6) && guard < 40) begin
      if (bus.rf_we) begin
        if (we_cnt == 0) we_at = cyc;
        we_cnt++;
        wbsel_at_we = bus.wb_sel;
        waddr_at_we = bus.rf_waddr;
      end
      if (bus.dmem_req) begin
        dreq_cnt++;
        daddr = bus.dmem_addr;
        bus.dmem_ack = (dreq_cnt == mem_wait);
      end else begin
        bus.dmem_ack = 1'b0;
      end
      step();
      cyc++;
      guard++;
    end
    bus.dmem_ack = 1'b0;
    n_total++;
    if (guard >= 40) $display("FAIL exec_timeout: state=%0d required=settled", state);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_data = '0;
    bus.dmem_ack = 1'b0;
    bus.alu_result = '0;
    bus.alu_flags = '0;
    step();
    n_total++;
    if (state !== 3'd0 || pc !== 8'h00 || flags !== 4'h0 || halted !== 1'b0)
      $display("FAIL reset_regs: state=%0d pc=%h flags=%h halted=%b required 0/00/0/0",
               state, pc, flags, halted);
    else n_pass++;
    n_total++;
    if (bus.imem_req !== 1'b0 || bus.rf_we !== 1'b0 || bus.dmem_req !== 1'b0 || bus.wb_sel !== 1'b0)
      $display("FAIL reset_strobes: imem_req=%b rf_we=%b dmem_req=%b wb_sel=%b required 0",
               bus.imem_req, bus.rf_we, bus.dmem_req, bus.wb_sel);
    else n_pass++;
    n_total++;
    if (bus.alu_opcode !== 4'h0 || bus.alu_imm !== 16'h0000)
      $display("FAIL reset_ir: opcode=%h imm=%h required 0/0000", bus.alu_opcode, bus.alu_imm);
    else n_pass++;
    reset = 1'b0;
    step();
    step();
    n_total++;
    if (state !== 3'd0) $display("FAIL idle_hold: state=%0d required=0", state);
    else n_pass++;
  endtask

  task automatic test_add();
    int we_cnt, we_at, dreq;
    logic wbs;
    logic [3:0] wa, expw;
    logic [7:0] da;
    run = 1'b1;
    step();
    n_total++;
    if (state !== 3'd1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00)
      $display("FAIL fetch_start: state=%0d req=%b addr=%h required 1/1/00",
               state, bus.imem_req, bus.imem_addr);
    else n_pass++;
    exp_q.push_back(4'd0);
    exec_one(32'h0000_0000, 32'h0, 4'h0, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (we_cnt !== 1 || we_at !== 4)
      $display("FAIL add_we: count=%0d cycle=%0d required 1/4", we_cnt, we_at);
    else n_pass++;
    expw = exp_q.pop_front();
    n_total++;
    if (wa !== expw || wbs !== 1'b0)
      $display("FAIL add_waddr: waddr=%h wb_sel=%b required %h/0", wa, wbs, expw);
    else n_pass++;
    n_total++;
    if (pc !== 8'h01 || state !== 3'd0 || bus.rf_we !== 1'b0)
      $display("FAIL add_end: pc=%h state=%0d rf_we=%b required 01/0/0", pc, state, bus.rf_we);
    else n_pass++;
  endtask

  task automatic test_cond();
    int we_cnt, we_at, dreq;
    logic wbs;
    logic [3:0] wa;
    logic [7:0] da;
    exec_one(mk(4'b0000, 4'b0010, 1'b1, 4'd2), 32'h0, 4'b0100, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (flags !== 4'b0100 || pc !== 8'h02)
      $display("FAIL sub_flags: flags=%b pc=%h required 0100/02", flags, pc);
    else n_pass++;
    exec_one(mk(4'b0001, 4'b0000, 1'b0, 4'd3), 32'h0, 4'b0000, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (we_cnt !== 1 || flags !== 4'b0100 || pc !== 8'h03 || bus.alu_cond !== 4'b0001)
      $display("FAIL eq_taken: we=%0d flags=%b pc=%h cond=%b required 1/0100/03/0001",
               we_cnt, flags, pc, bus.alu_cond);
    else n_pass++;
    exec_one(mk(4'b0000, 4'b0010, 1'b1, 4'd2), 32'h0, 4'b0000, 0, we_cnt, we_at, dreq, wbs, wa, da);
    exec_one(mk(4'b0001, 4'b0000, 1'b0, 4'd3), 32'h0, 4'b0000, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (we_cnt !== 0 || flags !== 4'b0000 || pc !== 8'h05 || state !== 3'd0)
      $display("FAIL eq_annul: we=%0d flags=%b pc=%h state=%0d required 0/0000/05/0",
               we_cnt, flags, pc, state);
    else n_pass++;
    exec_one(mk(4'b0001, 4'b1000, 1'b0, 4'd6), 32'h0, 4'b0000, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (we_cnt !== 1 || pc !== 8'h06)
      $display("FAIL cmp_unpredicated: we=%0d pc=%h required 1/06", we_cnt, pc);
    else n_pass++;
    exec_one(mk(4'b0100, 4'b0000, 1'b0, 4'd7), 32'h0, 4'b0000, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (we_cnt !== 1 || pc !== 8'h07)
      $display("FAIL ne_taken: we=%0d pc=%h required 1/07", we_cnt, pc);
    else n_pass++;
    exec_one(mk(4'b1010, 4'b0000, 1'b0, 4'd7), 32'h0, 4'b0000, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (we_cnt !== 0 || pc !== 8'h08)
      $display("FAIL never_annul: we=%0d pc=%h required 0/08", we_cnt, pc);
    else n_pass++;
    // N=1, V=0: LT passes, GE fails
    exec_one(mk(4'b0000, 4'b0010, 1'b1, 4'd1), 32'h0, 4'b1000, 0, we_cnt, we_at, dreq, wbs, wa, da);
    exec_one(mk(4'b0011, 4'b0000, 1'b0, 4'd1), 32'h0, 4'b0000, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (we_cnt !== 1 || pc !== 8'h0A)
      $display("FAIL lt_taken: we=%0d pc=%h required 1/0A", we_cnt, pc);
    else n_pass++;
    exec_one(mk(4'b0101, 4'b0000, 1'b0, 4'd1), 32'h0, 4'b0000, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (we_cnt !== 0 || pc !== 8'h0B)
      $display("FAIL ge_annul: we=%0d pc=%h required 0/0B", we_cnt, pc);
    else n_pass++;
  endtask

  task automatic test_ldr();
    int we_cnt, we_at, dreq;
    logic wbs;
    logic [3:0] wa, expw;
    logic [7:0] da;
    exp_q.push_back(4'd5);
    exec_one(mk(4'b0000, 4'b1001, 1'b0, 4'd5), 32'h0000_0042, 4'b0000, 3,
             we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (dreq !== 3 || da !== 8'h42)
      $display("FAIL ldr_dmem: req_cycles=%0d addr=%h required 3/42", dreq, da);
    else n_pass++;
    expw = exp_q.pop_front();
    n_total++;
    if (we_cnt !== 1 || wbs !== 1'b1 || wa !== expw)
      $display("FAIL ldr_wb: we=%0d wb_sel=%b waddr=%h required 1/1/%h", we_cnt, wbs, wa, expw);
    else n_pass++;
    n_total++;
    if (pc !== 8'h0C || bus.wb_sel !== 1'b0 || bus.dmem_req !== 1'b0)
      $display("FAIL ldr_end: pc=%h wb_sel=%b dmem_req=%b required 0C/0/0",
               pc, bus.wb_sel, bus.dmem_req);
    else n_pass++;
  endtask

  task automatic test_ignore_ack();
    bus.imem_ack = 1'b1;
    bus.imem_data = 32'hFFFF_FFFF;
    bus.dmem_ack = 1'b1;
    step();
    step();
    step();
    n_total++;
    if (state !== 3'd0 || bus.alu_opcode !== 4'b1001 || bus.dmem_req !== 1'b0)
      $display("FAIL stray_ack: state=%0d opcode=%b dmem_req=%b required 0/1001/0",
               state, bus.alu_opcode, bus.dmem_req);
    else n_pass++;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    run = 1'b1;
    step();
    n_total++;
    if (state !== 3'd1 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h0C)
      $display("FAIL mid_fetch: state=%0d req=%b addr=%h required 1/1/0C",
               state, bus.imem_req, bus.imem_addr);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (bus.imem_req !== 1'b0 || pc !== 8'h00 || state !== 3'd0)
      $display("FAIL async_reset: req=%b pc=%h state=%0d required 0/00/0",
               bus.imem_req, pc, state);
    else n_pass++;
    run = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_pc_wrap();
    int guard;
    int we_cnt, we_at, dreq;
    logic wbs;
    logic [3:0] wa;
    logic [7:0] da;
    run = 1'b1;
    guard = 0;
    while (!(state == 3'd1 && pc == 8'hFF) && guard < 3000) begin
      bus.imem_ack = (state == 3'd1);
      bus.imem_data = mk(4'b1111, 4'b0000, 1'b0, 4'd0);
      step();
      guard++;
    end
    bus.imem_ack = 1'b0;
    n_total++;
    if (pc !== 8'hFF || state !== 3'd1)
      $display("FAIL reach_ff: pc=%h state=%0d required FF/1", pc, state);
    else n_pass++;
    exec_one(mk(4'b0000, 4'b0000, 1'b0, 4'd4), 32'h0, 4'h0, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (pc !== 8'h00 || we_cnt !== 1)
      $display("FAIL pc_wrap: pc=%h we=%0d required 00/1", pc, we_cnt);
    else n_pass++;
  endtask

  task automatic test_halt();
    int we_cnt, we_at, dreq;
    int req_cnt;
    logic wbs;
    logic [3:0] wa;
    logic [7:0] da;
    exec_one(mk(4'b0000, 4'b1111, 1'b0, 4'd0), 32'h0, 4'h0, 0, we_cnt, we_at, dreq, wbs, wa, da);
    n_total++;
    if (state !== 3'd6 || halted !== 1'b1 || we_cnt !== 0 || pc !== 8'h00)
      $display("FAIL halt_enter: state=%0d halted=%b we=%0d pc=%h required 6/1/0/00",
               state, halted, we_cnt, pc);
    else n_pass++;
    run = 1'b1;
    bus.imem_ack = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.imem_req || bus.rf_we || bus.dmem_req) req_cnt++;
    end
    bus.imem_ack = 1'b0;
    n_total++;
    if (req_cnt !== 0 || state !== 3'd6 || halted !== 1'b1)
      $display("FAIL halt_sticky: strobes=%0d state=%0d halted=%b required 0/6/1",
               req_cnt, state, halted);
    else n_pass++;
    do_reset();
    n_total++;
    if (state !== 3'd0 || halted !== 1'b0)
      $display("FAIL halt_exit: state=%0d halted=%b required 0/0", state, halted);
    else n_pass++;
  endtask

`ifdef STALL_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    run = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    n_total++;
    if (state !== 3'd1 || timeout_err !== 1'b0)
      $display("FAIL timeout_early: state=%0d err=%b required 1/0", state, timeout_err);
    else n_pass++;
    step();
    n_total++;
    if (state !== 3'd6 || timeout_err !== 1'b1 || halted !== 1'b1 || bus.imem_req !== 1'b0)
      $display("FAIL timeout_halt: state=%0d err=%b halted=%b req=%b required 6/1/1/0",
               state, timeout_err, halted, bus.imem_req);
    else n_pass++;
    run = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_cond();
    test_ldr();
    test_ignore_ack();
    test_reset_mid_fetch();
    test_pc_wrap();
    test_halt();
`ifdef STALL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
